multicycle_ctrl: RTL and testbench

//  Sequencing control unit of the multicycle CPU; drives the PC register's PCWre and PCSrc.

---
 rtl/mc_pkg.sv | 54 +++++
 rtl/multicycle_ctrl_if.sv | 31 +++
 rtl/ctrl_decode.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 77 +++++++
 tb/tb_multicycle_ctrl.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: opcodes, FSM state encodings, instruction classes and select codes for the multicycle controller
package mc_pkg;
    localparam int OPW    = 6;
    localparam int ALUOPW = 3;

    localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
    localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
    localparam logic [OPW-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OPW-1:0] OP_AND   = 6'b010000;
    localparam logic [OPW-1:0] OP_ANDI  = 6'b010001;
    localparam logic [OPW-1:0] OP_ORI   = 6'b010010;
    localparam logic [OPW-1:0] OP_SLT   = 6'b011000;
    localparam logic [OPW-1:0] OP_SLL   = 6'b011100;
    localparam logic [OPW-1:0] OP_SW    = 6'b100110;
    localparam logic [OPW-1:0] OP_LW    = 6'b100111;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b110000;
    localparam logic [OPW-1:0] OP_BNE   = 6'b110001;
    localparam logic [OPW-1:0] OP_BLTZ  = 6'b110010;
    localparam logic [OPW-1:0] OP_J     = 6'b111000;
    localparam logic [OPW-1:0] OP_JR    = 6'b111001;
    localparam logic [OPW-1:0] OP_JAL   = 6'b111010;
    localparam logic [OPW-1:0] OP_HALT  = 6'b111111;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU, CL_LW, CL_SW, CL_BR, CL_J, CL_JAL, CL_JR, CL_HALT, CL_NOP
    } cls_t;

    localparam logic [ALUOPW-1:0] ALU_ADD = 3'd0;
    localparam logic [ALUOPW-1:0] ALU_SUB = 3'd1;
    localparam logic [ALUOPW-1:0] ALU_SLL = 3'd2;
    localparam logic [ALUOPW-1:0] ALU_OR  = 3'd3;
    localparam logic [ALUOPW-1:0] ALU_AND = 3'd4;
    localparam logic [ALUOPW-1:0] ALU_SLT = 3'd5;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_RS  = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: opcode/flag inputs and datapath control outputs of the multicycle controller
interface multicycle_ctrl_if;
    logic [mc_pkg::OPW-1:0]    Opcode;
    logic                      Zero;
    logic                      Sign;
    logic                      PCWre;
    logic [1:0]                PCSrc;
    logic                      IRWre;
    logic                      RegWre;
    logic [1:0]                RegDst;
    logic                      WrRegDSrc;
    logic                      ALUSrcA;
    logic                      ALUSrcB;
    logic                      ExtSel;
    logic [mc_pkg::ALUOPW-1:0] ALUOp;
    logic                      mRD;
    logic                      mWR;
    logic                      DBDataSrc;
    logic [2:0]                State;

    modport master (
        input  Opcode, Zero, Sign,
        output PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
               ExtSel, ALUOp, mRD, mWR, DBDataSrc, State
    );
    modport slave (
        output Opcode, Zero, Sign,
        input  PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
               ExtSel, ALUOp, mRD, mWR, DBDataSrc, State
    );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: opcode to instruction class and the static datapath selects
module ctrl_decode import mc_pkg::*; (
    input  logic [OPW-1:0]    opcode,
    output cls_t              cls,
    output logic [1:0]        reg_dst,
    output logic              wr_reg_d_src,
    output logic              alu_src_a,
    output logic              alu_src_b,
    output logic              ext_sel,
    output logic              db_data_src,
    output logic [ALUOPW-1:0] alu_op
);
    always_comb begin
        cls          = CL_NOP;
        reg_dst      = RD_RT;
        wr_reg_d_src = 1'b1;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        ext_sel      = 1'b0;
        db_data_src  = 1'b0;
        alu_op       = ALU_ADD;
        case (opcode)
            OP_ADD:   begin cls = CL_ALU; reg_dst = RD_RD; end
            OP_SUB:   begin cls = CL_ALU; reg_dst = RD_RD; alu_op = ALU_SUB; end
            OP_ADDIU: begin cls = CL_ALU; alu_src_b = 1'b1; ext_sel = 1'b1; end
            OP_AND:   begin cls = CL_ALU; reg_dst = RD_RD; alu_op = ALU_AND; end
            OP_ANDI:  begin cls = CL_ALU; alu_src_b = 1'b1; alu_op = ALU_AND; end
            OP_ORI:   begin cls = CL_ALU; alu_src_b = 1'b1; alu_op = ALU_OR; end
            OP_SLT:   begin cls = CL_ALU; reg_dst = RD_RD; alu_op = ALU_SLT; end
            OP_SLL:   begin cls = CL_ALU; reg_dst = RD_RD; alu_src_a = 1'b1; alu_op = ALU_SLL; end
            OP_SW:    begin cls = CL_SW; alu_src_b = 1'b1; ext_sel = 1'b1; end
            OP_LW:    begin cls = CL_LW; alu_src_b = 1'b1; ext_sel = 1'b1; db_data_src = 1'b1; end
            OP_BEQ, OP_BNE, OP_BLTZ: begin cls = CL_BR; ext_sel = 1'b1; alu_op = ALU_SUB; end
            OP_J:     cls = CL_J;
            OP_JR:    cls = CL_JR;
            OP_JAL:   begin cls = CL_JAL; reg_dst = RD_RA; wr_reg_d_src = 1'b0; end
            OP_HALT:  cls = CL_HALT;
            default:  cls = CL_NOP;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: five-phase instruction sequencer issuing one PCWre strobe per instruction
module multicycle_ctrl import mc_pkg::*; (
    input  logic CLK,
    input  logic RST,
    multicycle_ctrl_if.master bus
);
    state_t state_q, state_d;
    logic   halt_q, halt_d, pcwre_q, pcwre_d;
    cls_t   cls;
    logic   run, taken, id_fin;

    ctrl_decode u_dec (
        .opcode      (bus.Opcode),
        .cls         (cls),
        .reg_dst     (bus.RegDst),
        .wr_reg_d_src(bus.WrRegDSrc),
        .alu_src_a   (bus.ALUSrcA),
        .alu_src_b   (bus.ALUSrcB),
        .ext_sel     (bus.ExtSel),
        .db_data_src (bus.DBDataSrc),
        .alu_op      (bus.ALUOp)
    );

    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        case (state_q)
            S_IF:     state_d = S_ID;
            S_ID:     begin
                state_d = cls == CL_ALU ? S_EXE_AL :
                          (cls == CL_LW || cls == CL_SW) ? S_EXE_LS :
                          cls == CL_BR ? S_EXE_BR :
                          cls == CL_HALT ? S_ID : S_IF;
                halt_d  = cls == CL_HALT;
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL:  state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = cls == CL_LW ? S_WB_LD : S_IF;
            S_WB_LD:  state_d = S_IF;
            S_EXE_BR: state_d = S_IF;
        endcase
        if (halt_q) begin
            state_d = state_q;
            halt_d  = 1'b1;
        end
        pcwre_d = (state_d inside {S_EXE_BR, S_WB_AL, S_WB_LD}) || (state_d == S_MEM && cls == CL_SW);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IF;
            halt_q  <= 1'b0;
            pcwre_q <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            pcwre_q <= pcwre_d;
        end
    end

    // The opcode is only valid once ID is entered, so ID-final strobes are decoded there directly
    assign run    = RST && !halt_q;
    assign id_fin = state_q == S_ID && (cls inside {CL_J, CL_JAL, CL_JR, CL_NOP});
    assign taken  = (bus.Opcode == OP_BEQ && bus.Zero) || (bus.Opcode == OP_BNE && !bus.Zero) ||
                    (bus.Opcode == OP_BLTZ && bus.Sign);

    assign bus.PCWre  = !RST || (run && (pcwre_q || id_fin));
    assign bus.PCSrc  = !run ? PC_INC :
                        state_q == S_ID ? (cls == CL_JR ? PC_RS : (cls == CL_J || cls == CL_JAL) ? PC_JMP : PC_INC) :
                        (state_q == S_EXE_BR && taken) ? PC_BR : PC_INC;
    assign bus.IRWre  = run && state_q == S_IF;
    assign bus.RegWre = run && (state_q == S_WB_AL || state_q == S_WB_LD || (state_q == S_ID && cls == CL_JAL));
    assign bus.mRD    = run && state_q == S_MEM && cls == CL_LW;
    assign bus.mWR    = run && state_q == S_MEM && cls == CL_SW;
    assign bus.State  = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction stream checked against an instruction-level timing model
module tb_multicycle_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [5:0] ops [20] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                             6'b010010, 6'b011000, 6'b011100, 6'b100110, 6'b100111,
                             6'b110000, 6'b110001, 6'b110010, 6'b111000, 6'b111001,
                             6'b111010, 6'b000011, 6'b101010, 6'b111110, 6'b001111};

    multicycle_ctrl_if bus();
    multicycle_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // 0 alu, 1 lw, 2 sw, 3 branch, 4 j, 5 jal, 6 jr, 7 nop
    function automatic int cls_of(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b000010, 6'b010000,
            6'b010001, 6'b010010, 6'b011000, 6'b011100: return 0;
            6'b100111: return 1;
            6'b100110: return 2;
            6'b110000, 6'b110001, 6'b110010: return 3;
            6'b111000: return 4;
            6'b111010: return 5;
            6'b111001: return 6;
            default:   return 7;
        endcase
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic z, input logic s);
        int c, len, pulses;
        logic taken;
        logic [1:0] src;
        logic [2:0] st;
        c = cls_of(op);
        len = c == 0 ? 4 : c == 1 ? 5 : c == 2 ? 4 : c == 3 ? 3 : 2;
        taken = (op == 6'b110000 && z) || (op == 6'b110001 && !z) || (op == 6'b110010 && s);
        src = c == 3 ? (taken ? 2'd1 : 2'd0) : c == 6 ? 2'd2 : (c == 4 || c == 5) ? 2'd3 : 2'd0;
        pulses = 0;
        for (int k = 0; k < len; k++) begin
            bus.Opcode = k == 0 ? 6'($urandom) : op;
            bus.Zero = z;
            bus.Sign = s;
            @(negedge CLK);
            st = k == 0 ? 3'b000 : k == 1 ? 3'b001 :
                 c == 0 ? (k == 2 ? 3'b110 : 3'b111) :
                 c == 3 ? 3'b101 : k == 2 ? 3'b010 : k == 3 ? 3'b011 : 3'b100;
            check("state", 32'(bus.State), 32'(st));
            check("irwre", 32'(bus.IRWre), 32'(k == 0));
            check("pcwre", 32'(bus.PCWre), 32'(k == len - 1));
            check("pcsrc", 32'(bus.PCSrc), k == len - 1 ? 32'(src) : 32'd0);
            check("regwre", 32'(bus.RegWre), 32'(((c == 0 || c == 1) && k == len - 1) || (c == 5 && k == 1)));
            check("mrd", 32'(bus.mRD), 32'(c == 1 && k == 3));
            check("mwr", 32'(bus.mWR), 32'(c == 2 && k == 3));
            if (k > 0) begin
                case (op)
                    6'b000000: check("regdst_add", 32'(bus.RegDst), 32'd2);
                    6'b011100: check("alusrca_sll", 32'(bus.ALUSrcA), 32'd1);
                    6'b010001: begin
                        check("extsel_andi", 32'(bus.ExtSel), 32'd0);
                        check("alusrcb_andi", 32'(bus.ALUSrcB), 32'd1);
                    end
                    6'b000010: begin
                        check("extsel_addiu", 32'(bus.ExtSel), 32'd1);
                        check("regdst_addiu", 32'(bus.RegDst), 32'd1);
                    end
                    6'b100111: begin
                        check("dbsrc_lw", 32'(bus.DBDataSrc), 32'd1);
                        check("regdst_lw", 32'(bus.RegDst), 32'd1);
                    end
                    6'b111010: begin
                        check("regdst_jal", 32'(bus.RegDst), 32'd0);
                        check("wrsrc_jal", 32'(bus.WrRegDSrc), 32'd0);
                    end
                    default: ;
                endcase
            end
            pulses += int'(bus.PCWre);
            @(posedge CLK);
            #1;
        end
        check("pulses", 32'(pulses), 32'd1);
    endtask

    initial begin
        bus.Opcode = 6'b000000;
        bus.Zero = 1'b0;
        bus.Sign = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("rst_pcwre", 32'(bus.PCWre), 32'd1);
            check("rst_irwre", 32'(bus.IRWre), 32'd0);
            check("rst_regwre", 32'(bus.RegWre), 32'd0);
            check("rst_mem", 32'({bus.mRD, bus.mWR}), 32'd0);
            check("rst_pcsrc", 32'(bus.PCSrc), 32'd0);
        end
        check("rst_state", 32'(bus.State), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        run_instr(6'b000000, 1'b0, 1'b0);
        run_instr(6'b110000, 1'b1, 1'b0);
        run_instr(6'b110000, 1'b0, 1'b1);
        run_instr(6'b110010, 1'b0, 1'b1);
        run_instr(6'b110001, 1'b0, 1'b0);
        run_instr(6'b100111, 1'b0, 1'b0);
        run_instr(6'b100110, 1'b0, 1'b0);
        run_instr(6'b111010, 1'b0, 1'b0);
        run_instr(6'b111001, 1'b0, 1'b0);
        run_instr(6'b111000, 1'b0, 1'b0);
        run_instr(6'b000011, 1'b0, 1'b0);
        repeat (300) run_instr(ops[$urandom_range(0, 19)], 1'($urandom), 1'($urandom));

        bus.Opcode = 6'($urandom);
        @(negedge CLK);
        check("abort_if", 32'(bus.IRWre), 32'd1);
        @(posedge CLK);
        #1;
        bus.Opcode = 6'b100110;
        @(negedge CLK);
        check("abort_id", 32'(bus.State), 32'd1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("abort_exe", 32'(bus.State), 32'd2);
        check("abort_mwr", 32'(bus.mWR), 32'd0);
        check("abort_pcwre", 32'(bus.PCWre), 32'd1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("abort_state", 32'(bus.State), 32'd0);
        check("abort_mwr2", 32'(bus.mWR), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        run_instr(6'b000000, 1'b0, 1'b0);

        bus.Opcode = 6'($urandom);
        @(negedge CLK);
        check("halt_if", 32'(bus.IRWre), 32'd1);
        @(posedge CLK);
        #1;
        bus.Opcode = 6'b111111;
        @(negedge CLK);
        check("halt_id", 32'(bus.State), 32'd1);
        check("halt_id_pcwre", 32'(bus.PCWre), 32'd0);
        repeat (10) begin
            @(posedge CLK);
            #1;
            bus.Zero = 1'($urandom);
            bus.Sign = 1'($urandom);
            @(negedge CLK);
            check("halt_pcwre", 32'(bus.PCWre), 32'd0);
            check("halt_en", 32'({bus.IRWre, bus.RegWre, bus.mRD, bus.mWR}), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
